// File: rtl/data_mem_sb_pkg.sv
// Shared types and sizes for the data memory with coalescing store buffer.
//   SB_DEPTH  : default store-buffer entry count
//   MEM_WORDS : default data-array word count
//   ADDR_W    : word address width
//   DATA_W    : data word width
//   CNT_W     : occupancy counter width (holds 0..SB_DEPTH)
//   sb_entry_t: one buffered store (valid, addr, data)
package data_mem_sb_pkg;

    localparam int unsigned SB_DEPTH  = 4;
    localparam int unsigned MEM_WORDS = 128;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 3;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/data_mem_sb_store_buffer.sv
// Coalescing FIFO store buffer: entry storage, head/tail pointers, occupancy
// and the address match used for both coalescing and load forwarding.
//   clk, rst_n  : clock, async active-low reset
//   push        : store this cycle (addr/wdata)
//   pop         : drain head entry this cycle (ignored when push coalesces)
//   addr, wdata : access address and store data
//   hit_c       : a valid entry holds addr
//   hit_data_c  : data of the matching entry
//   head_c      : current head entry (drain source)
//   count       : occupancy 0..DEPTH
//   empty       : count == 0
//   full_c      : count == DEPTH
module store_buffer
    import data_mem_sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              hit_c,
    output logic [DATA_W-1:0] hit_data_c,
    output sb_entry_t         head_c,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] hit_idx_c;
    logic             coalesce_c;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
    endfunction

    // Addresses are unique in the buffer thanks to coalescing, so at most one hit.
    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        hit_data_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entries[i].valid && (entries[i].addr == addr)) begin
                hit_c      = 1'b1;
                hit_idx_c  = PTR_W'(i);
                hit_data_c = entries[i].data;
            end
        end
    end

    assign head_c     = entries[head];
    assign full_c     = (count == CNT_W'(DEPTH));
    assign coalesce_c = push & hit_c;

    // Coalesce wins over any pop; a forced pop on a full buffer frees the
    // slot the tail write then reuses (head == tail when full).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            empty <= 1'b1;
        end else if (coalesce_c) begin
            entries[hit_idx_c].data <= wdata;
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= next_ptr(head);
            end
            if (push) begin
                entries[tail] <= '{valid: 1'b1, addr: addr, data: wdata};
                tail          <= next_ptr(tail);
            end
            if (push && !pop) begin
                count <= CNT_W'(count + CNT_W'(1));
                empty <= 1'b0;
            end else if (pop && !push) begin
                count <= CNT_W'(count - CNT_W'(1));
                empty <= (count == CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/data_mem_sb.sv
// Word-addressed data memory fronted by a coalescing store buffer.
// Stores never stall; the single array port is used only by drains, which
// happen on idle cycles or when a new-address store hits a full buffer.
//   clk, rst_n  : clock, async active-low reset (also clears the array)
//   CEN         : access enable
//   WEN         : store request (wins over OEN)
//   OEN         : load request
//   A           : word address
//   Data2Mem    : store data
//   ReadDataMem : combinational load data, 0 when no load
//   sb_count    : store-buffer occupancy
//   sb_empty    : store buffer empty
module data_mem_sb
    import data_mem_sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned WORDS = MEM_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Data2Mem,
    output logic [DATA_W-1:0] ReadDataMem,
    output logic [CNT_W-1:0]  sb_count,
    output logic              sb_empty
);

    logic              store_c;
    logic              load_c;
    logic              drain_c;
    logic              hit_c;
    logic [DATA_W-1:0] hit_data_c;
    logic              full_c;
    sb_entry_t         head_c;
    logic [DATA_W-1:0] mem [WORDS];

    assign store_c = CEN & WEN;
    assign load_c  = CEN & OEN & ~WEN;

    // Drain on idle cycles, or forced when a new address arrives at a full buffer.
    assign drain_c = (~CEN & ~sb_empty) | (store_c & ~hit_c & full_c);

    store_buffer #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (store_c),
        .pop        (drain_c),
        .addr       (A),
        .wdata      (Data2Mem),
        .hit_c      (hit_c),
        .hit_data_c (hit_data_c),
        .head_c     (head_c),
        .count      (sb_count),
        .empty      (sb_empty),
        .full_c     (full_c)
    );

    // Data array; written only by drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                mem[i] <= '0;
            end
        end else if (drain_c) begin
            mem[head_c.addr] <= head_c.data;
        end
    end

    // Load path: buffered data takes precedence over the array.
    always_comb begin
        ReadDataMem = '0;
        if (rst_n && load_c) begin
            ReadDataMem = hit_c ? hit_data_c : mem[A];
        end
    end

endmodule

// File: tb/tb_data_mem_sb.sv
// Directed self-checking bench for data_mem_sb.
module tb_data_mem_sb;

    logic        clk;
    logic        rst_n;
    logic        CEN;
    logic        WEN;
    logic        OEN;
    logic [6:0]  A;
    logic [31:0] Data2Mem;
    logic [31:0] ReadDataMem;
    logic [2:0]  sb_count;
    logic        sb_empty;

    int checks;
    int errors;

    data_mem_sb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .CEN         (CEN),
        .WEN         (WEN),
        .OEN         (OEN),
        .A           (A),
        .Data2Mem    (Data2Mem),
        .ReadDataMem (ReadDataMem),
        .sb_count    (sb_count),
        .sb_empty    (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic c, input logic w, input logic o,
                         input logic [6:0] a, input logic [31:0] d);
        CEN = c; WEN = w; OEN = o; A = a; Data2Mem = d;
    endtask

    // Advance past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, 7'd0, 32'h0);
        #12;
        checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", sb_count); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b want 1", sb_empty); end
        checks++; if (ReadDataMem !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", ReadDataMem); end
        drive(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_forward();
        drive(1'b1, 1'b1, 1'b0, 7'd3, 32'h11);
        step();
        drive(1'b1, 1'b0, 1'b1, 7'd3, 32'h0);
        settle();
        checks++; if (ReadDataMem !== 32'h11) begin errors++; $display("FAIL fwd_rdata got %h want 11", ReadDataMem); end
        checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL fwd_count got %0d want 1", sb_count); end
        checks++; if (dut.mem[3] !== 32'h0) begin errors++; $display("FAIL fwd_mem3 got %h want 0", dut.mem[3]); end
        step();
        drive(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b1, 7'd3, 32'h0);
        settle();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL fwd_drain_empty got %0b want 1", sb_empty); end
        checks++; if (ReadDataMem !== 32'h11) begin errors++; $display("FAIL fwd_array_rdata got %h want 11", ReadDataMem); end
        step();
    endtask

    task automatic test_coalesce();
        drive(1'b1, 1'b1, 1'b0, 7'd7, 32'hAA);
        step();
        drive(1'b1, 1'b1, 1'b0, 7'd7, 32'hBB);
        step();
        drive(1'b1, 1'b0, 1'b1, 7'd7, 32'h0);
        settle();
        checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL coal_count got %0d want 1", sb_count); end
        checks++; if (ReadDataMem !== 32'hBB) begin errors++; $display("FAIL coal_rdata got %h want bb", ReadDataMem); end
        step();
        drive(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        step();
        checks++; if (dut.mem[7] !== 32'hBB) begin errors++; $display("FAIL coal_mem7 got %h want bb", dut.mem[7]); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL coal_empty got %0b want 1", sb_empty); end
    endtask

    task automatic test_force_drain();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 7'(i), 32'h100 + 32'(i));
            step();
        end
        checks++; if (sb_count !== 3'd4) begin errors++; $display("FAIL fd_full_count got %0d want 4", sb_count); end
        drive(1'b1, 1'b1, 1'b0, 7'd5, 32'h105);
        step();
        checks++; if (sb_count !== 3'd4) begin errors++; $display("FAIL fd_count got %0d want 4", sb_count); end
        checks++; if (dut.mem[1] !== 32'h101) begin errors++; $display("FAIL fd_mem1 got %h want 101", dut.mem[1]); end
        checks++; if (dut.mem[2] !== 32'h0) begin errors++; $display("FAIL fd_mem2 got %h want 0", dut.mem[2]); end
        drive(1'b1, 1'b0, 1'b1, 7'd1, 32'h0);
        settle();
        checks++; if (ReadDataMem !== 32'h101) begin errors++; $display("FAIL fd_load1 got %h want 101", ReadDataMem); end
        step();
        drive(1'b1, 1'b0, 1'b1, 7'd2, 32'h0);
        settle();
        checks++; if (ReadDataMem !== 32'h102) begin errors++; $display("FAIL fd_load2 got %h want 102", ReadDataMem); end
        step();
        checks++; if (sb_count !== 3'd4) begin errors++; $display("FAIL fd_load_nodrain got %0d want 4", sb_count); end
        drive(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        for (int i = 0; i < 4; i++) step();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL fd_empty got %0b want 1", sb_empty); end
        checks++; if (dut.mem[5] !== 32'h105) begin errors++; $display("FAIL fd_mem5 got %h want 105", dut.mem[5]); end
        checks++; if (dut.mem[4] !== 32'h104) begin errors++; $display("FAIL fd_mem4 got %h want 104", dut.mem[4]); end
    endtask

    task automatic test_idle_drain();
        drive(1'b1, 1'b1, 1'b0, 7'd10, 32'hA0); step();
        drive(1'b1, 1'b1, 1'b0, 7'd11, 32'hB0); step();
        drive(1'b1, 1'b1, 1'b0, 7'd12, 32'hC0); step();
        checks++; if (sb_count !== 3'd3) begin errors++; $display("FAIL idle_count3 got %0d want 3", sb_count); end
        drive(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        step();
        checks++; if (sb_count !== 3'd2) begin errors++; $display("FAIL idle_count2 got %0d want 2", sb_count); end
        checks++; if (dut.mem[10] !== 32'hA0) begin errors++; $display("FAIL idle_mem10 got %h want a0", dut.mem[10]); end
        checks++; if (dut.mem[11] !== 32'h0) begin errors++; $display("FAIL idle_mem11_early got %h want 0", dut.mem[11]); end
        step();
        checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL idle_count1 got %0d want 1", sb_count); end
        step();
        checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL idle_count0 got %0d want 0", sb_count); end
        checks++; if (dut.mem[11] !== 32'hB0) begin errors++; $display("FAIL idle_mem11 got %h want b0", dut.mem[11]); end
        checks++; if (dut.mem[12] !== 32'hC0) begin errors++; $display("FAIL idle_mem12 got %h want c0", dut.mem[12]); end
    endtask

    task automatic test_store_priority();
        drive(1'b1, 1'b1, 1'b1, 7'd9, 32'h55);
        settle();
        checks++; if (ReadDataMem !== 32'h0) begin errors++; $display("FAIL prio_rdata got %h want 0", ReadDataMem); end
        step();
        checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL prio_count got %0d want 1", sb_count); end
        drive(1'b1, 1'b0, 1'b1, 7'd9, 32'h0);
        settle();
        checks++; if (ReadDataMem !== 32'h55) begin errors++; $display("FAIL prio_load got %h want 55", ReadDataMem); end
        step();
        drive(1'b1, 1'b0, 1'b0, 7'd9, 32'h0);
        settle();
        checks++; if (ReadDataMem !== 32'h0) begin errors++; $display("FAIL noload_rdata got %h want 0", ReadDataMem); end
        step();
        checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL noload_nodrain got %0d want 1", sb_count); end
        drive(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        step();
        checks++; if (dut.mem[9] !== 32'h55) begin errors++; $display("FAIL prio_mem9 got %h want 55", dut.mem[9]); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0, 7'd40, 32'h4040); step();
        drive(1'b1, 1'b1, 1'b0, 7'd41, 32'h4141); step();
        drive(1'b1, 1'b0, 1'b1, 7'd40, 32'h0);
        #2;
        checks++; if (ReadDataMem !== 32'h4040) begin errors++; $display("FAIL rm_pre_rdata got %h want 4040", ReadDataMem); end
        rst_n = 1'b0;
        #1;
        checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL rm_count got %0d want 0", sb_count); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL rm_empty got %0b want 1", sb_empty); end
        checks++; if (ReadDataMem !== 32'h0) begin errors++; $display("FAIL rm_rdata got %h want 0", ReadDataMem); end
        checks++; if (dut.mem[3] !== 32'h0) begin errors++; $display("FAIL rm_mem3 got %h want 0", dut.mem[3]); end
        drive(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drive(1'b1, 1'b0, 1'b1, 7'd40, 32'h0);
        settle();
        checks++; if (ReadDataMem !== 32'h0) begin errors++; $display("FAIL rm_load40 got %h want 0", ReadDataMem); end
        step();
        drive(1'b1, 1'b0, 1'b1, 7'd41, 32'h0);
        settle();
        checks++; if (ReadDataMem !== 32'h0) begin errors++; $display("FAIL rm_load41 got %h want 0", ReadDataMem); end
        step();
        drive(1'b1, 1'b0, 1'b1, 7'd7, 32'h0);
        settle();
        checks++; if (ReadDataMem !== 32'h0) begin errors++; $display("FAIL rm_load7 got %h want 0", ReadDataMem); end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        test_reset();
        test_forward();
        test_coalesce();
        test_force_drain();
        test_idle_drain();
        test_store_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
